// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM states and flag bit positions
// for the accumulator ALU (accum_alu) and its multiplier.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDC = 4'd1,
    OP_SUB  = 4'd2,
    OP_SUBB = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NOTA = 4'd7,
    OP_INC  = 4'd8,
    OP_DEC  = 4'd9,
    OP_SHL  = 4'd10,
    OP_SHR  = 4'd11,
    OP_MUL  = 4'd12,
    OP_LOAD = 4'd13
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: N-cycle shift-add unsigned multiplier (only with ALU_MUL_EN).
// Ports: start loads a/b, run steps once per cycle, done marks the final
// step, product is the 2N-bit value that step produces.
`ifdef ALU_MUL_EN
module alu_mul_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           run,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  logic [2*N-1:0] mcand_q, mcand_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic [2*N-1:0] prod_step;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  always_comb begin
    prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    if (start) begin
      mcand_d  = {{N{1'b0}}, a};
      mplier_d = b;
      prod_d   = '0;
      cnt_d    = '0;
    end else if (run) begin
      prod_d   = prod_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  // The last step's sum is handed out directly so the top can
  // retire in the same edge as the final iteration.
  assign done    = run && (cnt_q == CW'(N - 1));
  assign product = prod_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/accum_alu.sv
// accum_alu: handshaked N-bit ALU with accumulator and sticky {V,N,Z,C}.
// Ports: in_valid/in_ready accept a,b,op,use_acc; out_valid/out_ready
// hand off y,flags; busy = multiply running. ALU_MUL_EN enables op 12.
module accum_alu
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   op,
  input  logic         use_acc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic [3:0]   flags,
  output logic         busy
);

  localparam logic [N:0] ONE = (N + 1)'(1);

  state_e       state_q, state_d;
  logic [N-1:0] acc_q, acc_d;
  logic [3:0]   flags_q, flags_d;

  logic [N-1:0] opa;
  logic [N:0]   sum;
  logic [N-1:0] res;
  logic         cin;
  logic         c;
  logic         v;
  logic         arith;
  logic [3:0]   fl_alu;

`ifdef ALU_MUL_EN
  logic           mul_start;
  logic           mul_done;
  logic [2*N-1:0] mul_prod;

  alu_mul_seq #(.N(N)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (opa),
    .b       (b),
    .run     (state_q == ST_MUL),
    .done    (mul_done),
    .product (mul_prod)
  );
`endif

  always_comb begin
    opa   = use_acc ? acc_q : a;
    cin   = flags_q[FLAG_C];
    sum   = '0;
    res   = '0;
    c     = 1'b0;
    v     = 1'b0;
    arith = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        arith = 1'b1;
        sum   = {1'b0, opa} + {1'b0, b};
        v     = (opa[N-1] == b[N-1]) && (sum[N-1] != opa[N-1]);
      end
      OP_ADDC: begin
        arith = 1'b1;
        sum   = {1'b0, opa} + {1'b0, b} + {{N{1'b0}}, cin};
        v     = (opa[N-1] == b[N-1]) && (sum[N-1] != opa[N-1]);
      end
      OP_SUB: begin
        arith = 1'b1;
        sum   = {1'b0, opa} - {1'b0, b};
        v     = (opa[N-1] != b[N-1]) && (sum[N-1] != opa[N-1]);
      end
      OP_SUBB: begin
        arith = 1'b1;
        sum   = {1'b0, opa} - {1'b0, b} - {{N{1'b0}}, cin};
        v     = (opa[N-1] != b[N-1]) && (sum[N-1] != opa[N-1]);
      end
      OP_INC: begin
        arith = 1'b1;
        sum   = {1'b0, opa} + ONE;
        v     = !opa[N-1] && sum[N-1];
      end
      OP_DEC: begin
        arith = 1'b1;
        sum   = {1'b0, opa} - ONE;
        v     = opa[N-1] && !sum[N-1];
      end
      OP_AND:  res = opa & b;
      OP_OR:   res = opa | b;
      OP_XOR:  res = opa ^ b;
      OP_NOTA: res = ~opa;
      OP_SHL: begin
        res = {opa[N-2:0], 1'b0};
        c   = opa[N-1];
      end
      OP_SHR: begin
        res = {1'b0, opa[N-1:1]};
        c   = opa[0];
      end
      OP_LOAD: res = b;
      default: res = '0;
    endcase
    if (arith) begin
      res = sum[N-1:0];
      c   = sum[N];
    end
    fl_alu = {v, res[N-1], res == '0, c};
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    flags_d = flags_q;
`ifdef ALU_MUL_EN
    mul_start = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef ALU_MUL_EN
          if (op_e'(op) == OP_MUL) begin
            state_d   = ST_MUL;
            mul_start = 1'b1;
          end else
`endif
          begin
            state_d = ST_HOLD;
            acc_d   = res;
            flags_d = fl_alu;
          end
        end
      end
      ST_MUL: begin
`ifdef ALU_MUL_EN
        if (mul_done) begin
          state_d = ST_HOLD;
          acc_d   = mul_prod[N-1:0];
          flags_d = {1'b0, mul_prod[N-1],
                     mul_prod[N-1:0] == '0,
                     |mul_prod[2*N-1:N]};
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_HOLD);
  assign y         = acc_q;
  assign flags     = flags_q;
`ifdef ALU_MUL_EN
  assign busy = (state_q == ST_MUL);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_accum_alu.sv
// tb_accum_alu: directed vectors for accum_alu with hand-computed
// results, latency, back-pressure and reset-abort checks.
module tb_accum_alu;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   op;
  logic         use_acc;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] y;
  logic [3:0]   flags;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  accum_alu #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .use_acc   (use_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flags     (flags),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns just after the accept edge.
  task automatic send(input string tag, input logic [3:0] o,
                      input logic [7:0] aa, input logic [7:0] bb,
                      input logic ua);
    chk({tag, "/rdy"}, 32'(in_ready), 1);
    in_valid = 1'b1;
    op       = o;
    a        = aa;
    b        = bb;
    use_acc  = ua;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 4'd13;
    a        = 8'h5A;
    b        = 8'hC3;
    use_acc  = 1'b0;
  endtask

  task automatic collect(input string tag, input logic [7:0] ey,
                         input logic [3:0] ef, input int elat,
                         input int ebusy);
    int lat;
    int nb;
    lat = 0;
    nb  = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      if (busy) nb++;
      lat++;
      @(negedge clk);
    end
    chk({tag, "/lat"}, lat, elat);
    chk({tag, "/busy"}, nb, ebusy);
    chk({tag, "/y"}, 32'(y), 32'(ey));
    chk({tag, "/flags"}, 32'(flags), 32'(ef));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "/ovdrop"}, 32'(out_valid), 0);
    chk({tag, "/rdyup"}, 32'(in_ready), 1);
  endtask

  task automatic run(input string tag, input logic [3:0] o,
                     input logic [7:0] aa, input logic [7:0] bb,
                     input logic ua, input logic [7:0] ey,
                     input logic [3:0] ef);
    send(tag, o, aa, bb, ua);
    collect(tag, ey, ef, 0, 0);
    consume(tag);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    use_acc   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst/rdy", 32'(in_ready), 0);
    chk("rst/ov", 32'(out_valid), 0);
    chk("rst/y", 32'(y), 0);
    chk("rst/flags", 32'(flags), 0);
    chk("rst/busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst/rdy1", 32'(in_ready), 1);

    // flags are {V,N,Z,C}
    run("add_ovf", 4'd0,  8'h7F, 8'h01, 1'b0, 8'h80, 4'b1100);
    run("add_cy",  4'd0,  8'hFF, 8'h01, 1'b0, 8'h00, 4'b0011);
    run("addc",    4'd1,  8'hEE, 8'h00, 1'b1, 8'h01, 4'b0000);
    run("sub_bw",  4'd2,  8'h00, 8'h01, 1'b0, 8'hFF, 4'b0101);
    run("subb",    4'd3,  8'h11, 8'h00, 1'b1, 8'hFE, 4'b0100);
    run("and",     4'd4,  8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000);
    run("or_z",    4'd5,  8'h00, 8'h00, 1'b0, 8'h00, 4'b0010);
    run("xor",     4'd6,  8'hAA, 8'hFF, 1'b0, 8'h55, 4'b0000);
    run("nota",    4'd7,  8'h0F, 8'h00, 1'b0, 8'hF0, 4'b0100);
    run("inc_v",   4'd8,  8'h7F, 8'h00, 1'b0, 8'h80, 4'b1100);
    run("inc_c",   4'd8,  8'hFF, 8'h00, 1'b0, 8'h00, 4'b0011);
    run("dec_v",   4'd9,  8'h80, 8'h00, 1'b0, 8'h7F, 4'b1000);
    run("dec_c",   4'd9,  8'h00, 8'h00, 1'b0, 8'hFF, 4'b0101);
    run("shl",     4'd10, 8'h81, 8'h00, 1'b0, 8'h02, 4'b0001);
    run("shr",     4'd11, 8'h81, 8'h00, 1'b0, 8'h40, 4'b0001);
    run("shr0",    4'd11, 8'h02, 8'h00, 1'b0, 8'h01, 4'b0000);
    run("load",    4'd13, 8'h00, 8'h80, 1'b0, 8'h80, 4'b0100);
    run("ill14",   4'd14, 8'hFF, 8'hFF, 1'b0, 8'h00, 4'b0010);
    run("ill15",   4'd15, 8'h7F, 8'h01, 1'b0, 8'h00, 4'b0010);
    run("ld11",    4'd13, 8'h00, 8'h11, 1'b0, 8'h11, 4'b0000);
    run("acc_add", 4'd0,  8'hFF, 8'h22, 1'b1, 8'h33, 4'b0000);

`ifdef ALU_MUL_EN
    send("mul1", 4'd12, 8'h10, 8'h20, 1'b0);
    collect("mul1", 8'h00, 4'b0011, N, N);
    consume("mul1");
    send("mul2", 4'd12, 8'h05, 8'h03, 1'b0);
    collect("mul2", 8'h0F, 4'b0000, N, N);
    consume("mul2");
`else
    send("mul_off", 4'd12, 8'h10, 8'h20, 1'b0);
    collect("mul_off", 8'h00, 4'b0010, 0, 0);
    consume("mul_off");
`endif

    // back-pressure: result must hold and new requests be ignored
    send("bp", 4'd0, 8'h01, 8'h02, 1'b0);
    collect("bp", 8'h03, 4'b0000, 0, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      op       = 4'd13;
      b        = 8'hAA;
      @(negedge clk);
      chk($sformatf("bp%0d/y", i), 32'(y), 32'h03);
      chk($sformatf("bp%0d/fl", i), 32'(flags), 0);
      chk($sformatf("bp%0d/ov", i), 32'(out_valid), 1);
      chk($sformatf("bp%0d/rdy", i), 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    consume("bp");
    run("bp_next", 4'd0, 8'h00, 8'h01, 1'b1, 8'h04, 4'b0000);

    // reset while holding a result with carry set
    send("rhold", 4'd0, 8'hFF, 8'h02, 1'b0);
    @(negedge clk);
    chk("rhold/ov", 32'(out_valid), 1);
    chk("rhold/y", 32'(y), 32'h01);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rhold/ov0", 32'(out_valid), 0);
    chk("rhold/y0", 32'(y), 0);
    chk("rhold/fl0", 32'(flags), 0);
    chk("rhold/rdy", 32'(in_ready), 1);
    run("rhold_acc", 4'd1, 8'hFF, 8'h05, 1'b1, 8'h05, 4'b0000);

`ifdef ALU_MUL_EN
    // reset during the third multiply cycle
    send("rmul", 4'd12, 8'h05, 8'h03, 1'b0);
    repeat (3) @(negedge clk);
    chk("rmul/busy1", 32'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rmul/ov", 32'(out_valid), 0);
    chk("rmul/busy", 32'(busy), 0);
    chk("rmul/y", 32'(y), 0);
    chk("rmul/fl", 32'(flags), 0);
    run("rmul_acc", 4'd0, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b0010);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/accum_alu.md
# accum_alu

Registered, handshaked N-bit ALU with an internal accumulator, a persistent status-flag register and an optional multi-cycle multiply. It generalises the lab combinational ALU into a sequential datapath unit: operands are accepted through a valid/ready handshake, results are held until consumed, and carry/borrow chains across operations for multi-word arithmetic. It sits between an operand source (register file or testbench sequencer) and a result sink.

## Interface
- N, 8, datapath width (N >= 2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand/op presented
- in_ready  output  1  block can accept this cycle
- a  input  N  operand A (ignored when use_acc=1)
- b  input  N  operand B
- op  input  4  operation code
- use_acc  input  1  1: operand A comes from the accumulator
- out_valid  output  1  result held on y/flags
- out_ready  input  1  sink consumes result
- y  output  N  result
- flags  output  4  {V, N, Z, C}; registered status
- busy  output  1  multiply in progress

## Operation
- Ops: 0 ADD A+B; 1 ADDC A+B+C; 2 SUB A-B; 3 SUBB A-B-C; 4 AND; 5 OR; 6 XOR; 7 NOTA ~A; 8 INC A+1; 9 DEC A-1; 10 SHL A<<1; 11 SHR A>>1 (logical); 12 MUL A*B low N bits; 13 LOAD y=B; 14-15 illegal: y=0.
- Arithmetic computed at N+1 bits; C = bit N. Subtraction: C=1 means borrow (A-B-cin negative as unsigned).
- V: add-type: a[N-1]==b'[N-1] and y[N-1]!=a[N-1]; sub-type: a[N-1]!=b[N-1] and y[N-1]!=a[N-1]; INC/DEC treat b'=1. Non-arithmetic ops: V=0.
- SHL: C = A[N-1]; SHR: C = A[0]. Logic ops, NOTA, LOAD, illegal: C=0.
- MUL: C = 1 if any bit of the 2N-bit product above N-1 is set; V=0.
- Z = (y==0), N = y[N-1], for every op.
- Every completed op writes y into the accumulator and updates all four flags.
- FSM states: IDLE, MUL, HOLD. IDLE: accept on in_valid && in_ready; MUL op -> MUL, else -> HOLD with result registered. MUL: N iterations shift-add, then -> HOLD. HOLD: out_valid=1; on out_ready -> IDLE.
- in_ready = (state==IDLE). Inputs sampled only on the accept cycle; changes afterwards ignored.
- use_acc with ADDC/SUBB uses the accumulator and stored C, enabling multi-word chains.

## Timing
- Reset: y=0, flags=0, accumulator=0, out_valid=0, busy=0, state IDLE; in_ready=0 while rst=1, 1 the cycle after.
- Single-cycle ops: accept at edge k, out_valid=1 after edge k (latency 1).
- MUL: busy=1 for N cycles after accept; out_valid=1 after N+1 edges.
- out_valid, y, flags stable until the out_ready edge; back-pressure holds indefinitely.
- HOLD with out_ready=1: out_valid drops next cycle, in_ready rises same cycle; no accept/consume overlap (max throughput: one op per 2 cycles).
- rst mid-MUL or in HOLD: aborts, result discarded, all state to reset values next edge.

## Configuration
- ALU_MUL_EN defined: op 12 performs multi-cycle multiply; MUL state and multiplier sub-module instantiated.
- Undefined: op 12 behaves as illegal (y=0, Z=1, other flags 0, latency 1); busy tied 0; no multiplier logic.

## Structure
- Package alu_pkg: op-code enum/localparams, FSM state encoding, flag bit indices (C=0, Z=1, N=2, V=3).
- Sub-module alu_mul_seq: N-cycle shift-add unsigned multiplier with start/done, 2N-bit product; only under ALU_MUL_EN.

## Test plan
- Reset then ADD a=8'h7F, b=8'h01 -> y=8'h80, flags V=1 N=1 Z=0 C=0, out_valid one cycle after accept.
- ADD a=8'hFF b=8'h01 then ADDC use_acc=1 b=8'h00 -> first y=00 C=1 Z=1; second y=01 C=0.
- SUB a=8'h00 b=8'h01 -> y=8'hFF C=1 (borrow) N=1; SUBB use_acc=1 b=8'h00 -> y=8'hFE C=0.
- MUL a=8'h10 b=8'h20 (ALU_MUL_EN) -> busy 8 cycles, y=8'h00 C=1 Z=1; a=8'h05 b=8'h03 -> y=8'h0F C=0.
- Back-pressure: hold out_ready=0 for 5 cycles after result -> y/flags unchanged, in_ready=0; in_valid ignored until consumed.
- Assert rst during MUL cycle 3 -> next cycle out_valid=0, busy=0, y=0, flags=0, accumulator=0.
